// File: rtl/io_pkg.sv
// Shared IO definitions: register offsets, STATUS bit positions, TX FSM states.
package io_pkg;

  // Register select values (io_addr[3:2])
  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  // STATUS bit positions
  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy count; reusable by IO peripherals.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == {CW{1'b0}});
  assign pop_ok_s   = pop_i & ~empty_o;
  // A push while full still fits when a pop frees a slot on the same edge.
  assign push_ok_s  = push_i & (~full_o | pop_ok_s);
  assign overflow_o = push_i & ~push_ok_s;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Occupancy next-state from accepted push/pop
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset since pointers restart
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divisor.
module io_uart_tx
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_write_data,
  input  logic        io_write_en,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_s, wr_s;
  logic [1:0]    sel_s;
  logic [15:0]   baud_div_q;
  logic          irq_en_q, ovf_q;
  logic          fifo_full_s, fifo_empty_s, fifo_ovf_s, pop_s;
  logic [7:0]    fifo_rdata_s;
  logic [CW-1:0] fifo_count_s;
  logic [31:0]   status_s;
  logic          busy_s;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  assign hit_s  = (io_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s  = io_addr[3:2];
  assign wr_s   = io_write_en & hit_s;
  assign busy_s = (state_q != ST_IDLE);

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_s && (sel_s == REG_TXDATA)),
    .wdata_i    (io_write_data[7:0]),
    .pop_i      (pop_s),
    .rdata_o    (fifo_rdata_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .count_o    (fifo_count_s),
    .overflow_o (fifo_ovf_s)
  );

  // Assemble STATUS word
  always_comb begin
    status_s                 = 32'd0;
    status_s[STAT_FULL]      = fifo_full_s;
    status_s[STAT_EMPTY]     = fifo_empty_s;
    status_s[STAT_BUSY]      = busy_s;
    status_s[STAT_OVF]       = ovf_q;
    status_s[STAT_CNT_LSB+:8] = 8'(fifo_count_s);
  end

  // Combinational register read mux; misses read as zero
  always_comb begin
    io_read_data = 32'd0;
    if (hit_s) begin
      case (sel_s)
        REG_STATUS:   io_read_data = status_s;
        REG_BAUD_DIV: io_read_data = {16'd0, baud_div_q};
        REG_CTRL:     io_read_data = {31'd0, irq_en_q};
        default:      io_read_data = 32'd0;
      endcase
    end else begin
      io_read_data = 32'd0;
    end
  end

  // Control registers; a fresh overflow wins over a simultaneous W1C clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div_q <= DEFAULT_DIV;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_s && (sel_s == REG_BAUD_DIV)) baud_div_q <= io_write_data[15:0];
      if (wr_s && (sel_s == REG_CTRL))     irq_en_q   <= io_write_data[0];
      if (fifo_ovf_s)                      ovf_q      <= 1'b1;
      else if (wr_s && (sel_s == REG_STATUS) && io_write_data[STAT_OVF]) ovf_q <= 1'b0;
    end
  end

  // Transmit FSM next-state: each bit lasts baud_div+1 clocks, reload at cnt==0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          cnt_d   = baud_div_q;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = baud_div_q;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = baud_div_q;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_rdata_s;
            cnt_d   = baud_div_q;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transmit FSM state register; line forced idle-high on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_en_q & fifo_empty_s & ~busy_s;

endmodule
